// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: byte FIFO on a valid/ready push port,
// serialised as 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop).
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_HALVES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       overflow
);

  // state  | meaning
  // IDLE   | lines idle-high, waiting for a queued byte with inhibit low
  // HIGH   | ps2_clk high half of a bit, ps2_data = shift[0]
  // LOW    | ps2_clk low half of a bit, host samples ps2_data
  // GAP    | idle-high spacing after the stop bit
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int GAP_N = (GAP_HALVES > 0) ? GAP_HALVES * CLK_DIV : 1;
  localparam int TMAX  = (GAP_N > CLK_DIV) ? GAP_N : CLK_DIV;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_N - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   shift_q, shift_d;
  logic          ps2_clk_q, ps2_clk_d;
  logic          ps2_data_q, ps2_data_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic       push;
  logic       pop;
  logic [7:0] head;

  assign in_ready = (count_q != FULL_CNT);
  assign busy     = (state_q != S_IDLE);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];

  // Pop decision uses only registered FIFO state, so a fresh push waits a cycle.
  assign push = in_valid && in_ready;
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && !inhibit;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (in_valid & ~in_ready);
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    case (state_q)
      S_IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (pop) begin
          shift_d    = {1'b1, ~^head, head, 1'b0};
          bit_cnt_d  = 4'd0;
          tmr_d      = HALF_LOAD;
          ps2_data_d = 1'b0;
          state_d    = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tmr_q == '0) begin
          ps2_clk_d = 1'b0;
          tmr_d     = HALF_LOAD;
          state_d   = S_LOW;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOW: begin
        if (tmr_q == '0) begin
          ps2_clk_d = 1'b1;
          if (bit_cnt_q == 4'd10) begin
            ps2_data_d = 1'b1;
            tmr_d      = GAP_LOAD;
            state_d    = (GAP_HALVES > 0) ? S_GAP : S_IDLE;
          end else begin
            // Data only moves at the start of a high phase.
            shift_d    = {1'b0, shift_q[10:1]};
            ps2_data_d = shift_q[1];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            tmr_d      = HALF_LOAD;
            state_d    = S_HIGH;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clrn) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count and pointers.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a negedge monitor decodes frames and
// compares them against a scoreboard of pushed bytes; tasks check timing/flags.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV    = 8;
  localparam int GAP_HALVES = 4;
  localparam int FIFO_DEPTH = 4;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       inhibit = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  int          fall_cnt = 0;
  int          nbits = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] obs = '0;

  always #5 clock = ~clock;

  ps2_kbd_tx #(
    .CLK_DIV(CLK_DIV),
    .GAP_HALVES(GAP_HALVES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock),
    .clrn(clrn),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .inhibit(inhibit),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .busy(busy),
    .overflow(overflow)
  );

  // Frame monitor: sample ps2_data at each ps2_clk falling edge.
  always @(negedge clock) begin
    logic [7:0]  e;
    logic [10:0] ef;
    if (busy === 1'b0) nbits = 0;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      fall_cnt++;
      obs[nbits] = ps2_data;
      nbits++;
      if (nbits == 11) begin
        nbits = 0;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got frame %b, required no frame", obs);
        end else begin
          e  = exp_q.pop_front();
          ef = {1'b1, ~^e, e, 1'b0};
          if (obs !== ef) begin
            n_fail++;
            $display("FAIL frame_bits: got %b, required %b (byte %h)", obs, ef, e);
          end
        end
      end
    end
    prev_clk = ps2_clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; in_valid = 1'b1; in_data = 8'hAA; inhibit = 1'b0;
    step(3);
    n_assert++; if (ps2_clk !== 1'b1)  begin n_fail++; $display("FAIL reset_clk: got %b, required 1", ps2_clk); end
    n_assert++; if (ps2_data !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b, required 1", ps2_data); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
    n_assert++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
    in_valid = 1'b0; clrn = 1'b1;
    step(20);
    n_assert++; if (busy !== 1'b0 || fall_cnt != 0) begin
      n_fail++; $display("FAIL reset_empty: got busy=%b falls=%0d, required busy=0 falls=0", busy, fall_cnt);
    end
  endtask

  task automatic test_single();
    int first_fall = -1;
    int busy_cnt = 0;
    bit ok;
    in_valid = 1'b1; in_data = 8'h1C; exp_q.push_back(8'h1C);
    step(1);
    in_valid = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (i == 1) begin
        n_assert++; if (ps2_data !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL single_start: got data=%b busy=%b, required data=0 busy=1", ps2_data, busy);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      if (first_fall < 0 && ps2_clk === 1'b0) first_fall = i;
      if (busy !== 1'b1 && i > 1) break;
    end
    n_assert++; if (first_fall != CLK_DIV + 1) begin
      n_fail++; $display("FAIL single_first_fall: got %0d, required %0d", first_fall, CLK_DIV + 1);
    end
    n_assert++; if (busy_cnt != (22 + GAP_HALVES) * CLK_DIV) begin
      n_fail++; $display("FAIL single_busy_len: got %0d, required %0d", busy_cnt, (22 + GAP_HALVES) * CLK_DIV);
    end
    wait_drain(50, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_drain: got timeout, required frame"); end
  endtask

  task automatic test_back_to_back();
    int base;
    int idle = 0;
    bit seen = 1'b0;
    bit ok;
    base = fall_cnt;
    in_valid = 1'b1; in_data = 8'hF0; exp_q.push_back(8'hF0);
    step(1);
    in_data = 8'h1C; exp_q.push_back(8'h1C);
    step(1);
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fall_cnt >= base + 11) begin seen = 1'b1; break; end
      step(1);
    end
    n_assert++; if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_frame1: got %0d falls, required 11", fall_cnt - base); end
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (ps2_clk === 1'b1 && ps2_data === 1'b0) break;
      if (ps2_clk === 1'b1 && ps2_data === 1'b1) idle++;
    end
    n_assert++; if (idle != GAP_HALVES * CLK_DIV + 1) begin
      n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, required %0d", idle, GAP_HALVES * CLK_DIV + 1);
    end
    wait_drain(500, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_fifo_full();
    logic exp_rdy;
    bit ok;
    inhibit = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_rdy = (i <= FIFO_DEPTH);
      n_assert++; if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL full_ready_%0d: got %b, required %b", i, in_ready, exp_rdy);
      end
      in_valid = 1'b1; in_data = 8'(i);
      if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
      step(1);
    end
    in_valid = 1'b0;
    n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_set: got %b, required 1", overflow); end
    step(10);
    n_assert++; if (overflow !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_hold: got ovf=%b busy=%b, required ovf=1 busy=0", overflow, busy);
    end
    inhibit = 1'b0;
    wait_drain(1500, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); end
    n_assert++; if (overflow !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_sticky: got ovf=%b ready=%b, required ovf=1 ready=1", overflow, in_ready);
    end
  endtask

  task automatic test_inhibit();
    int base;
    bit ok;
    inhibit = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A; exp_q.push_back(8'h5A);
    step(1);
    in_valid = 1'b0;
    base = fall_cnt;
    step(100);
    n_assert++; if (fall_cnt != base || busy !== 1'b0 || ps2_clk !== 1'b1) begin
      n_fail++; $display("FAIL inh_hold: got falls=%0d busy=%b clk=%b, required 0,0,1", fall_cnt - base, busy, ps2_clk);
    end
    inhibit = 1'b0;
    step(1);
    n_assert++; if (busy !== 1'b1 || ps2_data !== 1'b0) begin
      n_fail++; $display("FAIL inh_release: got busy=%b data=%b, required busy=1 data=0", busy, ps2_data);
    end
    wait_drain(400, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inh_drain1: got timeout, required frame"); end
    in_valid = 1'b1; in_data = 8'h3E; exp_q.push_back(8'h3E);
    step(1);
    in_valid = 1'b0;
    step(60);
    inhibit = 1'b1;
    wait_drain(400, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inh_midframe: got %0d pending, required 0", exp_q.size()); end
    inhibit = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen = 1'b0;
    bit ok;
    base = fall_cnt;
    in_valid = 1'b1;
    in_data = 8'h1C; exp_q.push_back(8'h1C); step(1);
    in_data = 8'h55; exp_q.push_back(8'h55); step(1);
    in_data = 8'h66; exp_q.push_back(8'h66); step(1);
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fall_cnt >= base + 5) begin seen = 1'b1; break; end
      step(1);
    end
    n_assert++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rmid_bit4: got %0d falls, required 5", fall_cnt - base); end
    clrn = 1'b0;
    step(1);
    clrn = 1'b1;
    exp_q.delete();
    n_assert++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      n_fail++; $display("FAIL rmid_lines: got clk=%b data=%b, required 1,1", ps2_clk, ps2_data);
    end
    n_assert++; if (busy !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rmid_flags: got busy=%b ready=%b ovf=%b, required 0,1,0", busy, in_ready, overflow);
    end
    base = fall_cnt;
    step(300);
    n_assert++; if (fall_cnt != base || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_quiet: got falls=%0d busy=%b ready=%b, required 0,0,1", fall_cnt - base, busy, in_ready);
    end
    in_valid = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    step(1);
    in_valid = 1'b0;
    wait_drain(400, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_inhibit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
